addr_seq_ctrl: RTL and testbench
================================

ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 MEM_WAIT, 2, number of wait cycles per memory access; legal range 1..7.
REQ-002 Clk  in  1  system clock; all state changes on the rising edge.
REQ-003 Reset  in  1  one clock; reset is synchronous and active-low (0 = reset, sampled on the rising edge of Clk).
REQ-004 Run  in  1  level; leaves HALTED.
REQ-005 Continue  in  1  level; leaves a PAUSE state.
REQ-006 Opcode  in  4  IR[15:12].
REQ-007 IR_5  in  1  IR[5], immediate select; IR_11  in  1  IR[11], JSR vs JSRR.
REQ-008 BEN  in  1  registered branch-enable bit.
REQ-009 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load strobes.
REQ-010 GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high in any cycle.
REQ-011 PCMUX  out  2  PC source: 00 = PC+1, 01 = bus, 10 = address adder.
REQ-012 ADDR1MUX  out  1  0 = PC, 1 = SR1; ADDR2MUX  out  2  00 = zero, 01 = SEXT(IR[5:0]), 10 = SEXT(IR[8:0]), 11 = SEXT(IR[10:0]).
REQ-013 DRMUX  out  1  0 = IR[11:9], 1 = R7; SR1MUX  out  1  0 = IR[11:9], 1 = IR[8:6]; SR2MUX  out  1  0 = SR2, 1 = imm5; ALUK  out  2  00 = ADD, 01 = AND, 10 = NOT, 11 = PASSA.
REQ-014 Mem_OE, Mem_WE  out  1 each  active-high memory strobes.
REQ-015 State_dbg  out  5  current state encoding.

Function
REQ-016 Outputs are Moore: decoded from the current state and wait counter only; every output not named for a state is 0.
REQ-017 States: HALTED, FETCH1, FETCH2, FETCH3, DECODE, ADD, AND, NOT, BR, BR_TAKEN, JMP, JSR1, JSR2, LDR1, LDR2, LDR3, STR1, STR2, STR3, PAUSE1, PAUSE2.
REQ-018 HALTED -> FETCH1 when Run = 1; otherwise the FSM holds in HALTED.
REQ-019 FETCH1: GatePC, LD_MAR, LD_PC, PCMUX = 00; then FETCH2.
REQ-020 FETCH2: Mem_OE and LD_MDR held for exactly MEM_WAIT cycles, counted by a 3-bit wait counter; then FETCH3.
REQ-021 FETCH3: GateMDR, LD_IR; then DECODE. DECODE: LD_BEN; next state selected by Opcode.
REQ-022 Opcode dispatch: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR1, 0110 LDR1, 0111 STR1, 1101 PAUSE1; any other opcode -> FETCH1 (treated as NOP).
REQ-023 ADD/AND: SR1MUX = 1, SR2MUX = IR_5, ALUK = 00/01, GateALU, LD_REG, LD_CC; then FETCH1.
REQ-024 NOT: SR1MUX = 1, ALUK = 10, GateALU, LD_REG, LD_CC; then FETCH1.
REQ-025 BR: outputs idle; -> BR_TAKEN if BEN = 1, else FETCH1. BR_TAKEN: ADDR1MUX = 0, ADDR2MUX = 10, PCMUX = 10, LD_PC; then FETCH1.
REQ-026 JMP: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 00, PCMUX = 10, LD_PC; then FETCH1.
REQ-027 JSR1: GatePC, DRMUX = 1, LD_REG; then JSR2.
REQ-028 JSR2: if IR_11 = 1, ADDR1MUX = 0 and ADDR2MUX = 11; else ADDR1MUX = 1, SR1MUX = 1 and ADDR2MUX = 00; PCMUX = 10, LD_PC; then FETCH1.
REQ-029 LDR1/STR1: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 01, GateMARMUX, LD_MAR.
REQ-030 LDR2: Mem_OE and LD_MDR for MEM_WAIT cycles. LDR3: GateMDR, LD_REG, LD_CC; then FETCH1.
REQ-031 STR2: SR1MUX = 0, ALUK = 11, GateALU, LD_MDR. STR3: Mem_WE for MEM_WAIT cycles; then FETCH1.
REQ-032 PAUSE1: LD_LED; hold while Continue = 0, -> PAUSE2 on Continue = 1. PAUSE2: hold while Continue = 1, -> FETCH1 on Continue = 0.
REQ-033 The wait counter clears on entry to every wait state and never wraps; Mem_OE and Mem_WE are never high together.
REQ-034 Run and Continue are ignored outside HALTED and the PAUSE states.

Reset
REQ-035 Reset = 0 at a rising edge forces HALTED and clears the wait counter in that edge, including mid-wait and mid-pause.
REQ-036 In HALTED all strobes, gates and mux selects are 0.

Structure
REQ-037 Shared package addr_ctrl_pkg holds the state enum, opcode constants, and the PCMUX/ADDR2MUX/ALUK encodings.
REQ-038 The wait counter is one sub-module, mem_wait_ctr (load/clear, done flag).

Verification
REQ-039 Reset low for 2 cycles, then high with Run = 0 -> HALTED, all outputs 0.
REQ-040 Run = 1, Opcode = 0001, MEM_WAIT = 2 -> FETCH1, FETCH2 x2, FETCH3, DECODE, ADD, FETCH1 (7 edges).
REQ-041 Opcode = 0000, BEN = 1 -> BR_TAKEN with ADDR1MUX = 0, ADDR2MUX = 10, PCMUX = 10, LD_PC = 1; BEN = 0 -> goes straight to FETCH1.
REQ-042 Opcode = 0100, IR_11 = 0 -> JSR1 drives DRMUX = 1, LD_REG; JSR2 drives ADDR1MUX = 1, ADDR2MUX = 00.
REQ-043 Opcode = 0111 -> Mem_WE high for exactly 2 cycles and Mem_OE = 0 throughout STR3.
REQ-044 Opcode = 1101, toggle Continue 0 -> 1 -> 0 -> FETCH1; Reset = 0 during PAUSE1 or LDR2 -> HALTED next edge.

Source files
------------

// File: rtl/addr_ctrl_pkg.sv
// Shared types and encodings for the address/sequence controller:
// state enum, opcode constants, mux/ALU encodings and the per-state
// control-word decoder.
package addr_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED   = 5'd0,
        S_FETCH1   = 5'd1,
        S_FETCH2   = 5'd2,
        S_FETCH3   = 5'd3,
        S_DECODE   = 5'd4,
        S_ADD      = 5'd5,
        S_AND      = 5'd6,
        S_NOT      = 5'd7,
        S_BR       = 5'd8,
        S_BR_TAKEN = 5'd9,
        S_JMP      = 5'd10,
        S_JSR1     = 5'd11,
        S_JSR2     = 5'd12,
        S_LDR1     = 5'd13,
        S_LDR2     = 5'd14,
        S_LDR3     = 5'd15,
        S_STR1     = 5'd16,
        S_STR2     = 5'd17,
        S_STR3     = 5'd18,
        S_PAUSE1   = 5'd19,
        S_PAUSE2   = 5'd20
    } state_e;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    // States whose length is set by the memory wait counter
    function automatic logic is_wait_state(state_e s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

    // Control word for a state; anything not listed stays 0
    function automatic ctrl_t decode_ctrl(state_e s, logic ir_5, logic ir_11);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH1: begin
                c.gate_pc = 1'b1;
                c.ld_mar  = 1'b1;
                c.ld_pc   = 1'b1;
                c.pcmux   = PCMUX_INC;
            end
            S_FETCH2, S_LDR2: begin
                c.mem_oe = 1'b1;
                c.ld_mdr = 1'b1;
            end
            S_FETCH3: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
            end
            S_DECODE: c.ld_ben = 1'b1;
            S_ADD, S_AND: begin
                c.sr1mux   = 1'b1;
                c.sr2mux   = ir_5;
                c.aluk     = (s == S_ADD) ? ALUK_ADD : ALUK_AND;
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S_NOT: begin
                c.sr1mux   = 1'b1;
                c.aluk     = ALUK_NOT;
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S_BR_TAKEN: begin
                c.addr1mux = 1'b0;
                c.addr2mux = ADDR2_OFF9;
                c.pcmux    = PCMUX_ADDER;
                c.ld_pc    = 1'b1;
            end
            S_JMP: begin
                c.sr1mux   = 1'b1;
                c.addr1mux = 1'b1;
                c.addr2mux = ADDR2_ZERO;
                c.pcmux    = PCMUX_ADDER;
                c.ld_pc    = 1'b1;
            end
            S_JSR1: begin
                c.gate_pc = 1'b1;
                c.drmux   = 1'b1;
                c.ld_reg  = 1'b1;
            end
            S_JSR2: begin
                if (ir_11) begin
                    c.addr1mux = 1'b0;
                    c.addr2mux = ADDR2_OFF11;
                end else begin
                    c.addr1mux = 1'b1;
                    c.sr1mux   = 1'b1;
                    c.addr2mux = ADDR2_ZERO;
                end
                c.pcmux = PCMUX_ADDER;
                c.ld_pc = 1'b1;
            end
            S_LDR1, S_STR1: begin
                c.sr1mux      = 1'b1;
                c.addr1mux    = 1'b1;
                c.addr2mux    = ADDR2_OFF6;
                c.gate_marmux = 1'b1;
                c.ld_mar      = 1'b1;
            end
            S_LDR3: begin
                c.gate_mdr = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S_STR2: begin
                c.sr1mux   = 1'b0;
                c.aluk     = ALUK_PASSA;
                c.gate_alu = 1'b1;
                c.ld_mdr   = 1'b1;
            end
            S_STR3:   c.mem_we = 1'b1;
            S_PAUSE1: c.ld_led = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait counter: cleared on request, counts up and saturates at 7,
// flags the last cycle of a LIMIT-cycle access.
module mem_wait_ctr #(
    parameter int unsigned LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic done
);

    logic [2:0] count;

    // Count wait cycles; saturating so it can never wrap back to "done"
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != 3'd7) begin
            count <= count + 3'd1;
        end
    end

    assign done = (count == 3'(LIMIT - 1));

endmodule

// File: rtl/addr_seq_ctrl.sv
// Microsequencer for a small LC-3 style datapath: fetch/decode/execute FSM
// with memory wait states and a run/pause handshake.
module addr_seq_ctrl
    import addr_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [4:0] State_dbg
);

    state_e state;
    state_e state_nxt;
    ctrl_t  ctrl;
    logic   wait_done;
    logic   wait_clear;

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            S_HALTED: if (Run) state_nxt = S_FETCH1;
            S_FETCH1: state_nxt = S_FETCH2;
            S_FETCH2: if (wait_done) state_nxt = S_FETCH3;
            S_FETCH3: state_nxt = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_ADD:   state_nxt = S_ADD;
                    OP_AND:   state_nxt = S_AND;
                    OP_NOT:   state_nxt = S_NOT;
                    OP_BR:    state_nxt = S_BR;
                    OP_JMP:   state_nxt = S_JMP;
                    OP_JSR:   state_nxt = S_JSR1;
                    OP_LDR:   state_nxt = S_LDR1;
                    OP_STR:   state_nxt = S_STR1;
                    OP_PAUSE: state_nxt = S_PAUSE1;
                    default:  state_nxt = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR2, S_LDR3:
                state_nxt = S_FETCH1;
            S_BR:     state_nxt = BEN ? S_BR_TAKEN : S_FETCH1;
            S_JSR1:   state_nxt = S_JSR2;
            S_LDR1:   state_nxt = S_LDR2;
            S_LDR2:   if (wait_done) state_nxt = S_LDR3;
            S_STR1:   state_nxt = S_STR2;
            S_STR2:   state_nxt = S_STR3;
            S_STR3:   if (wait_done) state_nxt = S_FETCH1;
            S_PAUSE1: if (Continue) state_nxt = S_PAUSE2;
            S_PAUSE2: if (!Continue) state_nxt = S_FETCH1;
            default:  state_nxt = S_HALTED;
        endcase
    end

    // Any state change (or being outside a wait state) restarts the count,
    // so every wait state is entered with a zero count.
    assign wait_clear = (state_nxt != state) || !is_wait_state(state);

    mem_wait_ctr #(
        .LIMIT(MEM_WAIT)
    ) u_wait (
        .clk  (Clk),
        .rst_n(Reset),
        .clear(wait_clear),
        .done (wait_done)
    );

    // State register with control word registered from the state being entered,
    // so outputs are a pure function of the current state
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_HALTED;
            ctrl  <= '0;
        end else begin
            state <= state_nxt;
            ctrl  <= decode_ctrl(state_nxt, IR_5, IR_11);
        end
    end

    assign LD_MAR     = ctrl.ld_mar;
    assign LD_MDR     = ctrl.ld_mdr;
    assign LD_IR      = ctrl.ld_ir;
    assign LD_BEN     = ctrl.ld_ben;
    assign LD_CC      = ctrl.ld_cc;
    assign LD_REG     = ctrl.ld_reg;
    assign LD_PC      = ctrl.ld_pc;
    assign LD_LED     = ctrl.ld_led;
    assign GatePC     = ctrl.gate_pc;
    assign GateMDR    = ctrl.gate_mdr;
    assign GateALU    = ctrl.gate_alu;
    assign GateMARMUX = ctrl.gate_marmux;
    assign PCMUX      = ctrl.pcmux;
    assign ADDR1MUX   = ctrl.addr1mux;
    assign ADDR2MUX   = ctrl.addr2mux;
    assign DRMUX      = ctrl.drmux;
    assign SR1MUX     = ctrl.sr1mux;
    assign SR2MUX     = ctrl.sr2mux;
    assign ALUK       = ctrl.aluk;
    assign Mem_OE     = ctrl.mem_oe;
    assign Mem_WE     = ctrl.mem_we;
    assign State_dbg  = state;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Self-checking bench for addr_seq_ctrl: directed instruction sequences,
// expected state trace per instruction, per-state expected control word.
module tb_addr_seq_ctrl;
    import addr_ctrl_pkg::*;

    localparam int unsigned MW = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'b0000;
    logic       IR_5 = 1'b0;
    logic       IR_11 = 1'b0;
    logic       BEN = 1'b0;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       ADDR1MUX, DRMUX, SR1MUX, SR2MUX, Mem_OE, Mem_WE;
    logic [4:0] State_dbg;

    addr_seq_ctrl #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .State_dbg(State_dbg)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    typedef state_e sq_t[$];
    state_e exp_q[$];

    // Snapshots of specific states' outputs and strobe counters
    logic [5:0] br_snap;
    logic [1:0] jsr1_snap;
    logic [2:0] jsr2_snap;
    int         we_cycles;
    int         oe_in_str3;

    logic [23:0] act_ctrl;
    assign act_ctrl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                       GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR1MUX, ADDR2MUX,
                       DRMUX, SR1MUX, SR2MUX, ALUK, Mem_OE, Mem_WE};

    // Expected control outputs of each state, written from the state table
    function automatic logic [23:0] exp_ctrl(state_e s, logic ir5, logic ir11);
        logic ld_mar = 0, ld_mdr = 0, ld_ir = 0, ld_ben = 0, ld_cc = 0, ld_reg = 0;
        logic ld_pc = 0, ld_led = 0, g_pc = 0, g_mdr = 0, g_alu = 0, g_mm = 0;
        logic a1 = 0, dr = 0, sr1 = 0, sr2 = 0, oe = 0, we = 0;
        logic [1:0] pcm = 2'b00, a2 = 2'b00, alu = 2'b00;
        case (s)
            S_FETCH1:   begin g_pc = 1; ld_mar = 1; ld_pc = 1; end
            S_FETCH2:   begin oe = 1; ld_mdr = 1; end
            S_FETCH3:   begin g_mdr = 1; ld_ir = 1; end
            S_DECODE:   ld_ben = 1;
            S_ADD:      begin sr1 = 1; sr2 = ir5; g_alu = 1; ld_reg = 1; ld_cc = 1; end
            S_AND:      begin sr1 = 1; sr2 = ir5; alu = 2'b01; g_alu = 1; ld_reg = 1; ld_cc = 1; end
            S_NOT:      begin sr1 = 1; alu = 2'b10; g_alu = 1; ld_reg = 1; ld_cc = 1; end
            S_BR_TAKEN: begin a2 = 2'b10; pcm = 2'b10; ld_pc = 1; end
            S_JMP:      begin sr1 = 1; a1 = 1; pcm = 2'b10; ld_pc = 1; end
            S_JSR1:     begin g_pc = 1; dr = 1; ld_reg = 1; end
            S_JSR2:     begin
                if (ir11) a2 = 2'b11;
                else begin a1 = 1; sr1 = 1; end
                pcm = 2'b10; ld_pc = 1;
            end
            S_LDR1, S_STR1: begin sr1 = 1; a1 = 1; a2 = 2'b01; g_mm = 1; ld_mar = 1; end
            S_LDR2:     begin oe = 1; ld_mdr = 1; end
            S_LDR3:     begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
            S_STR2:     begin alu = 2'b11; g_alu = 1; ld_mdr = 1; end
            S_STR3:     we = 1;
            S_PAUSE1:   ld_led = 1;
            default:    ;
        endcase
        return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                g_pc, g_mdr, g_alu, g_mm, pcm, a1, a2, dr, sr1, sr2, alu, oe, we};
    endfunction

    // Expected state trace of one instruction, starting at FETCH1
    function automatic sq_t plan(logic [3:0] op, logic ben);
        sq_t q;
        q.push_back(S_FETCH1);
        repeat (MW) q.push_back(S_FETCH2);
        q.push_back(S_FETCH3);
        q.push_back(S_DECODE);
        case (op)
            4'b0001: q.push_back(S_ADD);
            4'b0101: q.push_back(S_AND);
            4'b1001: q.push_back(S_NOT);
            4'b0000: begin q.push_back(S_BR); if (ben) q.push_back(S_BR_TAKEN); end
            4'b1100: q.push_back(S_JMP);
            4'b0100: begin q.push_back(S_JSR1); q.push_back(S_JSR2); end
            4'b0110: begin
                q.push_back(S_LDR1);
                repeat (MW) q.push_back(S_LDR2);
                q.push_back(S_LDR3);
            end
            4'b0111: begin
                q.push_back(S_STR1);
                q.push_back(S_STR2);
                repeat (MW) q.push_back(S_STR3);
            end
            4'b1101: q.push_back(S_PAUSE1);
            default: ;
        endcase
        return q;
    endfunction

    // Compare process: one expected state per falling edge
    always @(negedge Clk) begin
        state_e e;
        logic [23:0] ec;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            ec = exp_ctrl(e, IR_5, IR_11);
            checks++;
            if (State_dbg != e) begin
                errors++;
                $display("FAIL state: got %0d, expected %0d (%s) at %0t", State_dbg, e, e.name(), $time);
            end
            checks++;
            if (act_ctrl != ec) begin
                errors++;
                $display("FAIL ctrl in %s: got %h, expected %h at %0t", e.name(), act_ctrl, ec, $time);
            end
        end
        checks++;
        if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1) begin
            errors++;
            $display("FAIL bus_gates: got %b, expected at most one high", {GatePC, GateMDR, GateALU, GateMARMUX});
        end
        checks++;
        if (Mem_OE && Mem_WE) begin
            errors++;
            $display("FAIL mem_strobes: got OE=1 WE=1, expected not both");
        end
        if (Mem_WE) we_cycles++;
        if (State_dbg == S_STR3 && Mem_OE) oe_in_str3++;
        if (State_dbg == S_BR_TAKEN) br_snap = {ADDR1MUX, ADDR2MUX, PCMUX, LD_PC};
        if (State_dbg == S_JSR1) jsr1_snap = {DRMUX, LD_REG};
        if (State_dbg == S_JSR2) jsr2_snap = {ADDR1MUX, ADDR2MUX};
    end

    task automatic expect_next(state_e s);
        exp_q.push_back(s);
        @(negedge Clk);
        #1;
    endtask

    task automatic run_instr(logic [3:0] op, logic ben, logic i5, logic i11, bit from_halt);
        sq_t q;
        Opcode = op; BEN = ben; IR_5 = i5; IR_11 = i11;
        q = plan(op, ben);
        for (int i = (from_halt ? 0 : 1); i < q.size(); i++) expect_next(q[i]);
        if (op != OP_PAUSE) expect_next(S_FETCH1);
    endtask

    task automatic check_lit(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sq_t q;
        // Reset, then idle in HALTED
        Reset = 1'b0;
        expect_next(S_HALTED);
        expect_next(S_HALTED);
        Reset = 1'b1; Run = 1'b0;
        expect_next(S_HALTED);
        expect_next(S_HALTED);
        check_lit("halted_outputs", int'(act_ctrl), 0);
        check_lit("halted_state", int'(State_dbg), 0);

        // ADD from HALTED: seven edges back to FETCH1
        q = plan(4'b0001, 1'b0);
        check_lit("add_edge_count", q.size() + 1, 7);
        Run = 1'b1;
        run_instr(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        Run = 1'b0;

        run_instr(4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);   // AND imm
        run_instr(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);   // NOT
        run_instr(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);   // unknown -> NOP
        run_instr(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);   // BR not taken
        br_snap = '0;
        run_instr(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);   // BR taken
        check_lit("br_taken_fields", int'(br_snap), 6'b0_10_10_1);
        Run = 1'b1;                                   // ignored outside HALTED
        run_instr(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);   // JMP
        Run = 1'b0;
        jsr1_snap = '0; jsr2_snap = 3'b011;
        run_instr(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);   // JSRR
        check_lit("jsr1_drmux_ldreg", int'(jsr1_snap), 2'b11);
        check_lit("jsr2_addr_sel", int'(jsr2_snap), 3'b1_00);
        run_instr(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);   // JSR
        run_instr(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);   // LDR
        we_cycles = 0; oe_in_str3 = 0;
        run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);   // STR
        check_lit("str_we_cycles", we_cycles, 2);
        check_lit("str3_oe_cycles", oe_in_str3, 0);

        // Pause handshake
        Continue = 1'b0;
        run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_next(S_PAUSE1);
        expect_next(S_PAUSE1);
        Continue = 1'b1;
        expect_next(S_PAUSE2);
        expect_next(S_PAUSE2);
        Continue = 1'b0;
        expect_next(S_FETCH1);

        // Reset while paused
        run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        expect_next(S_HALTED);
        Reset = 1'b1;
        expect_next(S_HALTED);

        // Reset in the middle of an LDR memory wait
        Run = 1'b1;
        Opcode = 4'b0110;
        q = plan(4'b0110, 1'b0);
        for (int i = 0; i < 7; i++) expect_next(q[i]);
        Reset = 1'b0;
        expect_next(S_HALTED);
        Reset = 1'b1; Run = 1'b0;
        expect_next(S_HALTED);

        // Restart: the wait counter must start from zero again
        Run = 1'b1;
        run_instr(4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
        Run = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
